// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
//   Bundles the three buses around the memory stage:
//     ex_*    execute -> memory stage instruction hand-off (ex_ready back-pressure)
//     dmem_*  data-memory request/ack channel
//     wb_*    writeback result plus the misaligned / access_fault status pulses
//   modport slave  : the memory stage itself
//   modport master : the environment (execute stage, data memory, writeback)
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
);
  logic                     ex_valid;
  logic                     ex_ready;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic                     ex_reg_write;
  logic [2:0]               ex_funct3;
  logic [DATA_WIDTH-1:0]    ex_alu_result;
  logic [DATA_WIDTH-1:0]    ex_store_data;
  logic [RF_ADDR_WIDTH-1:0] ex_rd;

  logic                     dmem_req;
  logic                     dmem_we;
  logic [DATA_WIDTH-1:0]    dmem_addr;
  logic [DATA_WIDTH-1:0]    dmem_wdata;
  logic [3:0]               dmem_be;
  logic                     dmem_ack;
  logic [DATA_WIDTH-1:0]    dmem_rdata;

  logic                     wb_valid;
  logic                     wb_we;
  logic [RF_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     misaligned;
  logic                     access_fault;

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
    input  ex_funct3, ex_alu_result, ex_store_data, ex_rd,
    output ex_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata,
    output wb_valid, wb_we, wb_rd, wb_data, misaligned, access_fault
  );

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
    output ex_funct3, ex_alu_result, ex_store_data, ex_rd,
    input  ex_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata,
    input  wb_valid, wb_we, wb_rd, wb_data, misaligned, access_fault
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//   Memory stage behind the ALU. Non-memory results pass straight through to
//   writeback one cycle after acceptance. Loads/stores are decoded on accept:
//   illegal or misaligned accesses retire immediately with a status pulse,
//   legal ones open a req/ack transaction and stall execute until it closes
//   (ack) or the wait timer expires (access_fault).
//
//   Ports
//     clk    in  rising-edge clock
//     reset  in  asynchronous, active-high
//     bus    lsu_mem_stage_if.slave : ex_*, dmem_*, wb_*, misaligned, access_fault
//
//   state | meaning
//   IDLE  | no transaction open, ex_ready=1, accepts one instruction per cycle
//   BUSY  | dmem_req held with latched fields, waiting for ack or timeout
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int MAX_WAIT      = 16
) (
  input logic          clk,
  input logic          reset,
  lsu_mem_stage_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Wait timer is a down-counter: loaded with MAX_WAIT-1 on entry to BUSY,
  // timeout fires when it reads zero in a cycle without ack.
  localparam int            CW       = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

  logic [0:0]               state_q, state_d;
  logic                     we_q, we_d;
  logic [DATA_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [3:0]               be_q, be_d;
  logic [2:0]               f3_q, f3_d;
  logic [1:0]               off_q, off_d;
  logic [RF_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     wb_valid_q, wb_valid_d;
  logic                     wb_we_q, wb_we_d;
  logic [RF_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
  logic                     mis_q, mis_d;
  logic                     fault_q, fault_d;

  logic                  accept;
  logic                  is_mem;
  logic                  illegal;
  logic                  misal;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_ext;

  assign accept = bus.ex_valid & (state_q == ST_IDLE);
  assign is_mem = bus.ex_mem_read | bus.ex_mem_write;

  always_comb begin
    illegal = (bus.ex_mem_read & bus.ex_mem_write)
            | (bus.ex_mem_read & ((bus.ex_funct3 == 3'b011) | (bus.ex_funct3 == 3'b110) |
                                  (bus.ex_funct3 == 3'b111)))
            | (bus.ex_mem_write & (bus.ex_funct3 > 3'b010));
    misal   = ((bus.ex_funct3[1:0] == 2'b01) & bus.ex_alu_result[0])
            | ((bus.ex_funct3[1:0] == 2'b10) & (bus.ex_alu_result[1:0] != 2'b00));
  end

  // Store lanes are replicated so the byte enables alone select the target bytes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = '0;
    if (bus.ex_mem_write) begin
      case (bus.ex_funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << bus.ex_alu_result[1:0];
          st_wdata = {4{bus.ex_store_data[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << bus.ex_alu_result[1:0];
          st_wdata = {2{bus.ex_store_data[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = bus.ex_store_data;
        end
      endcase
    end
  end

  // LW is always word-aligned here, so lane equals rdata for it.
  always_comb begin
    lane = bus.dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'b0, lane[7:0]};
      3'b101:  load_ext = {16'b0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mis_d      = 1'b0;
    fault_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wb_rd_d = bus.ex_rd;
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = bus.ex_reg_write & (bus.ex_rd != '0);
            wb_data_d  = bus.ex_alu_result;
          end else if (illegal) begin
            wb_valid_d = 1'b1;
            fault_d    = 1'b1;
            wb_data_d  = bus.ex_alu_result;
          end else if (misal) begin
            wb_valid_d = 1'b1;
            mis_d      = 1'b1;
            wb_data_d  = bus.ex_alu_result;
          end else begin
            state_d = ST_BUSY;
            we_d    = bus.ex_mem_write;
            addr_d  = {bus.ex_alu_result[DATA_WIDTH-1:2], 2'b00};
            wdata_d = st_wdata;
            be_d    = st_be;
            f3_d    = bus.ex_funct3;
            off_d   = bus.ex_alu_result[1:0];
            rd_d    = bus.ex_rd;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        // ack in the terminal-count cycle still completes normally
        if (bus.dmem_ack) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (!we_q) begin
            wb_we_d   = (rd_q != '0);
            wb_data_d = load_ext;
          end
        end else if ((MAX_WAIT != 0) && (cnt_q == '0)) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          fault_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mis_q      <= mis_d;
      fault_q    <= fault_d;
    end
  end

  // Request is derived from the state register, so an async reset drops it at once.
  assign bus.ex_ready     = (state_q == ST_IDLE) & ~reset;
  assign bus.dmem_req     = (state_q == ST_BUSY);
  assign bus.dmem_we      = we_q;
  assign bus.dmem_addr    = addr_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.dmem_be      = be_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_we        = wb_we_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misaligned   = mis_q;
  assign bus.access_fault = fault_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
//   Directed and randomized stimulus for lsu_mem_stage (MAX_WAIT=4), checked
//   against an access model built from the architectural load/store rules.
// ---------------------------------------------------------------------------
module tb_lsu_mem_stage;

  localparam int MW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int tests = 0;
  int fails = 0;

  lsu_mem_stage_if #(.DATA_WIDTH(32), .RF_ADDR_WIDTH(5)) bus ();

  lsu_mem_stage #(.DATA_WIDTH(32), .RF_ADDR_WIDTH(5), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // kind: 0 non-memory, 1 illegal, 2 misaligned, 3 memory transaction
  typedef struct packed {
    logic [1:0]  kind;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic exp_t model(input logic mr, input logic mw, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd);
    exp_t e;
    int   n;
    int   off;
    e = '0;
    off = int'(a % 4);
    if (!mr && !mw) begin
      e.kind = 2'd0;
      return e;
    end
    if ((mr && mw) || (mr && (f3 == 3 || f3 == 6 || f3 == 7)) || (mw && f3 > 2)) begin
      e.kind = 2'd1;
      return e;
    end
    n = nbytes_of(f3);
    if ((a % n) != 0) begin
      e.kind = 2'd2;
      return e;
    end
    e.kind = 2'd3;
    e.we   = mw;
    e.addr = a - (a % 4);
    if (mw) begin
      e.be = 4'(((1 << n) - 1) << off);
      if (n == 1)      e.wdata = (sd & 32'hFF) * 32'h0101_0101;
      else if (n == 2) e.wdata = (sd & 32'hFFFF) * 32'h0001_0001;
      else             e.wdata = sd;
    end else begin
      e.be    = 4'hF;
      e.wdata = 32'h0;
    end
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    logic [31:0] mask;
    int          n;
    n = nbytes_of(f3);
    v = rdata >> (8 * off);
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Issues one instruction from IDLE and checks everything up to the cycle
  // after retirement. ad = req cycle in which ack is given (> MW: never).
  task automatic do_op(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                       input int ad, input logic [31:0] rdata);
    exp_t e;
    bit   acked;
    e = model(mr, mw, f3, a, sd);
    acked = 0;
    chk("ex_ready_idle", bus.ex_ready, 1);
    bus.ex_valid      = 1'b1;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    bus.ex_reg_write  = rw;
    bus.ex_funct3     = f3;
    bus.ex_alu_result = a;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    step();
    bus.ex_valid = 1'b0;
    if (e.kind != 2'd3) begin
      chk("wb_valid_fast", bus.wb_valid, 1);
      chk("wb_we_fast", bus.wb_we, (e.kind == 2'd0) ? 32'(rw && rd != 0) : 32'd0);
      chk("misaligned", bus.misaligned, 32'(e.kind == 2'd2));
      chk("access_fault", bus.access_fault, 32'(e.kind == 2'd1));
      chk("no_req", bus.dmem_req, 0);
      chk("ex_ready_fast", bus.ex_ready, 1);
      if (e.kind == 2'd0) begin
        chk("wb_rd_pass", bus.wb_rd, rd);
        chk("wb_data_pass", bus.wb_data, a);
      end
    end else begin
      for (int k = 1; k <= MW; k++) begin
        chk("req_held", bus.dmem_req, 1);
        chk("ex_ready_busy", bus.ex_ready, 0);
        chk("dmem_we", bus.dmem_we, e.we);
        chk("dmem_addr", bus.dmem_addr, e.addr);
        chk("dmem_be", bus.dmem_be, e.be);
        if (mw) chk("dmem_wdata", bus.dmem_wdata, e.wdata);
        chk("wb_quiet_busy", bus.wb_valid, 0);
        if (k == ad) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdata;
          acked = 1;
        end
        step();
        bus.dmem_ack = 1'b0;
        if (acked) break;
      end
      chk("wb_valid_done", bus.wb_valid, 1);
      chk("req_dropped", bus.dmem_req, 0);
      chk("ex_ready_done", bus.ex_ready, 1);
      chk("misaligned_done", bus.misaligned, 0);
      if (acked) begin
        chk("access_fault_ok", bus.access_fault, 0);
        chk("wb_we_done", bus.wb_we, mw ? 32'd0 : 32'(rd != 0));
        if (!mw) begin
          chk("wb_rd_load", bus.wb_rd, rd);
          chk("wb_data_load", bus.wb_data, model_load(f3, int'(a % 4), rdata));
        end
      end else begin
        chk("timeout_fault", bus.access_fault, 1);
        chk("wb_we_timeout", bus.wb_we, 0);
      end
    end
    step();
    chk("wb_single_pulse", bus.wb_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ex_valid      = 1'b0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_mem_write  = 1'b0;
    bus.ex_reg_write  = 1'b0;
    bus.ex_funct3     = 3'b0;
    bus.ex_alu_result = 32'h0;
    bus.ex_store_data = 32'h0;
    bus.ex_rd         = 5'd0;
    bus.dmem_ack      = 1'b0;
    bus.dmem_rdata    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_ready", bus.ex_ready, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    chk("rst_be", bus.dmem_be, 0);
    chk("rst_faults", {30'b0, bus.misaligned, bus.access_fault}, 0);
    reset = 1'b0;
    #1;
    chk("ex_ready_after_rst", bus.ex_ready, 1);
    step();

    // ADD-style passthrough
    do_op(0, 0, 1, 3'b000, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    // rd=0 never writes
    do_op(0, 0, 1, 3'b000, 32'hDEAD, 32'h0, 5'd0, 0, 32'h0);
    // LB / LBU from byte 3, ack in third req cycle
    do_op(1, 0, 0, 3'b000, 32'h103, 32'h0, 5'd7, 3, 32'h80FF_FFFF);
    do_op(1, 0, 0, 3'b100, 32'h103, 32'h0, 5'd7, 3, 32'h80FF_FFFF);
    // SH upper half
    do_op(0, 1, 0, 3'b001, 32'h102, 32'hABCD_1234, 5'd3, 1, 32'h0);
    // misaligned LW
    do_op(1, 0, 0, 3'b010, 32'h101, 32'h0, 5'd9, 0, 32'h0);
    // LW timeout and ack in the terminal cycle
    do_op(1, 0, 0, 3'b010, 32'h200, 32'h0, 5'd4, MW + 1, 32'h0);
    do_op(1, 0, 0, 3'b010, 32'h204, 32'h0, 5'd4, MW, 32'hCAFE_F00D);
    // illegal encodings
    do_op(1, 1, 0, 3'b010, 32'h300, 32'h0, 5'd1, 0, 32'h0);
    do_op(1, 0, 0, 3'b011, 32'h300, 32'h0, 5'd1, 0, 32'h0);
    do_op(0, 1, 0, 3'b100, 32'h300, 32'h0, 5'd1, 0, 32'h0);

    // back-to-back passthroughs
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0;
    bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd10; bus.ex_alu_result = 32'h1111_0000;
    step();
    chk("b2b_first_valid", bus.wb_valid, 1);
    chk("b2b_first_data", bus.wb_data, 32'h1111_0000);
    bus.ex_rd = 5'd11; bus.ex_alu_result = 32'h2222_0000;
    step();
    bus.ex_valid = 1'b0;
    chk("b2b_second_valid", bus.wb_valid, 1);
    chk("b2b_second_rd", bus.wb_rd, 5'd11);
    chk("b2b_second_data", bus.wb_data, 32'h2222_0000);
    step();

    // stray ack while idle
    bus.dmem_ack = 1'b1;
    step();
    bus.dmem_ack = 1'b0;
    chk("idle_ack_ignored", bus.wb_valid, 0);

    // reset during BUSY, late ack afterwards
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_funct3 = 3'b010;
    bus.ex_alu_result = 32'h400; bus.ex_rd = 5'd6;
    step();
    bus.ex_valid = 1'b0; bus.ex_mem_read = 1'b0;
    chk("pre_rst_req", bus.dmem_req, 1);
    step();
    reset = 1'b1;
    #1;
    chk("rst_async_req", bus.dmem_req, 0);
    chk("rst_async_ready", bus.ex_ready, 0);
    step();
    reset = 1'b0;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h5555_5555;
    step();
    bus.dmem_ack = 1'b0;
    chk("late_ack_no_wb", bus.wb_valid, 0);
    chk("late_ack_no_req", bus.dmem_req, 0);
    step();
    chk("late_ack_no_wb2", bus.wb_valid, 0);
    do_op(1, 0, 0, 3'b001, 32'h402, 32'h0, 5'd8, 2, 32'h8001_7FFF);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      int          sel;
      logic        mr, mw, rw;
      logic [2:0]  f3;
      logic [31:0] a;
      sel = int'($urandom_range(0, 9));
      mr = (sel >= 2 && sel <= 5) || sel == 9;
      mw = (sel >= 6);
      rw = 1'($urandom_range(0, 1));
      f3 = mw && !mr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      do_op(mr, mw, rw, f3, a, $urandom, 5'($urandom_range(0, 31)),
            int'($urandom_range(1, 6)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
